// File: rtl/soc_mmio_pkg.sv
// Shared widths, window decode constants and responder FSM states.
// Offsets are addr[3:0] within a 4K window selected by addr[18:12].
package soc_mmio_pkg;

  localparam int DATA_W      = 19;
  localparam int ADDR_W      = 19;
  localparam int RAM_AW_DEF  = 8;
  localparam int TIMEOUT_DEF = 255;

  localparam logic [6:0] FFT_WIN_BASE    = 7'h7F;
  localparam logic [6:0] CRYPTO_WIN_BASE = 7'h06;

  localparam logic [3:0] FFT_CTRL   = 4'h0;
  localparam logic [3:0] FFT_RESULT = 4'h1;
  localparam logic [3:0] CR_CTRL    = 4'h0;
  localparam logic [3:0] CR_KEY     = 4'h1;
  localparam logic [3:0] CR_DIN     = 4'h2;
  localparam logic [3:0] CR_DOUT    = 4'h3;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

endpackage

// File: rtl/mmio_ram.sv
// Single-port data RAM: 1-cycle registered read, write-first, no reset on contents.
// Output only updates when enabled, so a read result holds until the next access.
module mmio_ram #(
  parameter int AW = 8,
  parameter int DW = 19
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
        rdata     <= wdata;
      end else begin
        rdata     <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mmio_responder.sv
// MMIO responder: RAM, FFT and crypto windows; response one cycle after accept, or after done/timeout.
// One request in flight: req_ready is high only in IDLE, so throughput is one request per 2 cycles.
module mmio_responder
  import soc_mmio_pkg::*;
#(
  parameter int         RAM_AW      = RAM_AW_DEF,
  parameter logic [6:0] FFT_BASE    = FFT_WIN_BASE,
  parameter logic [6:0] CRYPTO_BASE = CRYPTO_WIN_BASE,
  parameter int         TIMEOUT     = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] read_data,
  output logic              err,
  output logic              fft_start,
  input  logic              fft_done,
  input  logic [DATA_W-1:0] fft_result,
  output logic              crypto_start,
  output logic [DATA_W-1:0] crypto_key,
  output logic [DATA_W-1:0] crypto_din,
  input  logic              crypto_done,
  input  logic [DATA_W-1:0] crypto_dout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t state, state_nxt;

  logic [CNT_W-1:0]  wait_cnt;
  logic              wait_crypto;
  logic              rsp_err, rsp_ram;
  logic [DATA_W-1:0] rsp_data;
  logic              fft_busy_q, fft_done_q, cr_busy_q, cr_done_q;
  logic [DATA_W-1:0] fft_res, cr_res;
  logic [DATA_W-1:0] ram_rdata;

  logic              accept, win_fft, win_cr, fft_busy_eff, cr_busy_eff, wait_done;
  logic [3:0]        off;
  logic              dec_err, dec_wait, fft_go, cr_go, key_we, din_we, ram_hit;
  logic [DATA_W-1:0] dec_data;
  logic              unused_addr;

  // Next {busy, done}; a start in the same cycle as done wins over the completion.
  function automatic logic [1:0] track(input logic busy, input logic done_f,
                                       input logic go, input logic done_in);
    logic b, d;
    b = busy;
    d = done_f;
    if (busy && done_in) begin
      b = 1'b0;
      d = 1'b1;
    end
    if (go) begin
      b = 1'b1;
      d = 1'b0;
    end
    return {b, d};
  endfunction

  function automatic logic [DATA_W-1:0] ctrl_word(input logic busy, input logic done_f);
    return {{(DATA_W-2){1'b0}}, done_f, busy};
  endfunction

  assign accept       = req_valid & req_ready;
  assign win_fft      = (addr[ADDR_W-1:12] == FFT_BASE);
  assign win_cr       = (addr[ADDR_W-1:12] == CRYPTO_BASE);
  assign off          = addr[3:0];
  assign fft_busy_eff = fft_busy_q & ~fft_done;
  assign cr_busy_eff  = cr_busy_q & ~crypto_done;
  assign wait_done    = wait_crypto ? (crypto_done & cr_busy_q) : (fft_done & fft_busy_q);
  assign unused_addr  = ^addr;

  always_comb begin
    dec_err  = 1'b0;
    dec_data = '0;
    dec_wait = 1'b0;
    fft_go   = 1'b0;
    cr_go    = 1'b0;
    key_we   = 1'b0;
    din_we   = 1'b0;
    ram_hit  = 1'b0;
    if (win_fft) begin
      case (off)
        FFT_CTRL: begin
          if (!req_write)          dec_data = ctrl_word(fft_busy_q, fft_done_q);
          else if (write_data[0]) begin
            if (fft_busy_eff)      dec_err  = 1'b1;
            else                   fft_go   = 1'b1;
          end
        end
        FFT_RESULT: begin
          if (req_write)           dec_err  = 1'b1;
          else if (fft_busy_eff)   dec_wait = 1'b1;
          else                     dec_data = fft_busy_q ? fft_result : fft_res;
        end
        default:                   dec_err  = 1'b1;
      endcase
    end else if (win_cr) begin
      case (off)
        CR_CTRL: begin
          if (!req_write)          dec_data = ctrl_word(cr_busy_q, cr_done_q);
          else if (write_data[0]) begin
            if (cr_busy_eff)       dec_err  = 1'b1;
            else                   cr_go    = 1'b1;
          end
        end
        CR_KEY: begin
          if (!req_write)          dec_data = crypto_key;
          else if (cr_busy_eff)    dec_err  = 1'b1;
          else                     key_we   = 1'b1;
        end
        CR_DIN: begin
          if (!req_write)          dec_data = crypto_din;
          else if (cr_busy_eff)    dec_err  = 1'b1;
          else                     din_we   = 1'b1;
        end
        CR_DOUT: begin
          if (req_write)           dec_err  = 1'b1;
          else if (cr_busy_eff)    dec_wait = 1'b1;
          else                     dec_data = cr_busy_q ? crypto_dout : cr_res;
        end
        default:                   dec_err  = 1'b1;
      endcase
    end else begin
      ram_hit = 1'b1;
    end
  end

  mmio_ram #(.AW(RAM_AW), .DW(DATA_W)) u_ram (
    .clk   (clk),
    .en    (accept & ram_hit),
    .we    (req_write),
    .addr  (addr[RAM_AW-1:0]),
    .wdata (write_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = dec_wait ? WAIT : RESP;
      WAIT:    if (wait_done || wait_cnt == CNT_W'(TIMEOUT)) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) && rst_n;
    rsp_valid = (state == RESP);
    err       = (state == RESP) && rsp_err;
    read_data = '0;
    if (state == RESP) read_data = rsp_ram ? ram_rdata : rsp_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt     <= '0;
      wait_crypto  <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_ram      <= 1'b0;
      rsp_data     <= '0;
      fft_busy_q   <= 1'b0;
      fft_done_q   <= 1'b0;
      cr_busy_q    <= 1'b0;
      cr_done_q    <= 1'b0;
      fft_res      <= '0;
      cr_res       <= '0;
      fft_start    <= 1'b0;
      crypto_start <= 1'b0;
      crypto_key   <= '0;
      crypto_din   <= '0;
    end else begin
      fft_start    <= accept & fft_go;
      crypto_start <= accept & cr_go;
      {fft_busy_q, fft_done_q} <= track(fft_busy_q, fft_done_q, accept & fft_go, fft_done);
      {cr_busy_q, cr_done_q}   <= track(cr_busy_q, cr_done_q, accept & cr_go, crypto_done);
      if (fft_busy_q && fft_done)   fft_res    <= fft_result;
      if (cr_busy_q && crypto_done) cr_res     <= crypto_dout;
      if (accept && key_we)         crypto_key <= write_data;
      if (accept && din_we)         crypto_din <= write_data;

      case (state)
        IDLE: begin
          if (accept) begin
            rsp_err     <= dec_err;
            rsp_data    <= dec_data;
            rsp_ram     <= ram_hit & ~req_write;
            wait_crypto <= win_cr;
            wait_cnt    <= '0;
          end
        end
        WAIT: begin
          if (wait_done) begin
            rsp_err  <= 1'b0;
            rsp_data <= wait_crypto ? crypto_dout : fft_result;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_responder.sv
// Directed bench for mmio_responder: RAM, FFT/crypto windows, wait/timeout and reset-in-wait.
module tb_mmio_responder;

  localparam int BOUND = 600;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write;
  logic [18:0] addr, write_data;
  logic        req_ready, rsp_valid, err;
  logic [18:0] read_data;
  logic        fft_start, fft_done;
  logic [18:0] fft_result;
  logic        crypto_start, crypto_done;
  logic [18:0] crypto_key, crypto_din, crypto_dout;

  int checks = 0;
  int errors = 0;

  logic        r_err;
  logic [18:0] r_data;
  int          r_wait;
  logic        s_fft, s_cr, rdy_seen;

  always #5 clk = ~clk;

  mmio_responder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_write    (req_write),
    .addr         (addr),
    .write_data   (write_data),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .read_data    (read_data),
    .err          (err),
    .fft_start    (fft_start),
    .fft_done     (fft_done),
    .fft_result   (fft_result),
    .crypto_start (crypto_start),
    .crypto_key   (crypto_key),
    .crypto_din   (crypto_din),
    .crypto_done  (crypto_done),
    .crypto_dout  (crypto_dout)
  );

  // Issues one request and captures the response; r_wait counts cycles spent waiting after cycle T+1.
  task automatic do_req(input logic w, input logic [18:0] a, input logic [18:0] d);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin n++; @(negedge clk); end
    req_valid = 1'b1; req_write = w; addr = a; write_data = d;
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = 1'b0;
    n = 0; rdy_seen = 1'b0;
    @(negedge clk);
    s_fft = fft_start; s_cr = crypto_start;
    while (!rsp_valid && n < BOUND) begin
      if (req_ready) rdy_seen = 1'b1;
      n++;
      @(negedge clk);
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL rsp_timeout addr=%05h got rsp_valid=%b want 1", a, rsp_valid);
    end
    r_err = err; r_data = read_data; r_wait = n;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; addr = '0; write_data = '0;
    fft_done = 1'b0; fft_result = '0; crypto_done = 1'b0; crypto_dout = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b want 0", req_ready); end
    checks++; if ({rsp_valid, err, fft_start, crypto_start} !== 4'b0) begin errors++; $display("FAIL rst_strobes got %b want 0000", {rsp_valid, err, fft_start, crypto_start}); end
    checks++; if (read_data !== 19'd0) begin errors++; $display("FAIL rst_rdata got %0d want 0", read_data); end
    checks++; if ({crypto_key, crypto_din} !== 38'd0) begin errors++; $display("FAIL rst_key_din got %0h want 0", {crypto_key, crypto_din}); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %b want 1", req_ready); end
  endtask

  task automatic test_ram();
    do_req(1'b1, 19'h00100, 19'd123);
    checks++; if ({r_wait, r_err, r_data} !== {32'd0, 1'b0, 19'd0}) begin errors++; $display("FAIL ram_wr got wait=%0d err=%b data=%0d want 0/0/0", r_wait, r_err, r_data); end
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL ram_wr_pulse got %b want 0", rsp_valid); end
    do_req(1'b0, 19'h00100, 19'd0);
    checks++; if ({r_wait, r_err, r_data} !== {32'd0, 1'b0, 19'd123}) begin errors++; $display("FAIL ram_rd got wait=%0d err=%b data=%0d want 0/0/123", r_wait, r_err, r_data); end
    do_req(1'b1, 19'h00005, 19'd42);
    do_req(1'b0, 19'h00F05, 19'd0);
    checks++; if ({r_err, r_data} !== {1'b0, 19'd42}) begin errors++; $display("FAIL ram_alias got err=%b data=%0d want 0/42", r_err, r_data); end
  endtask

  task automatic test_fft_start();
    do_req(1'b1, 19'h7F000, 19'd1);
    checks++; if ({r_err, s_fft} !== 2'b01) begin errors++; $display("FAIL fft_start got err=%b start=%b want 0/1", r_err, s_fft); end
    @(negedge clk);
    checks++; if (fft_start !== 1'b0) begin errors++; $display("FAIL fft_start_len got %b want 0", fft_start); end
    do_req(1'b0, 19'h7F000, 19'd0);
    checks++; if ({r_err, r_data} !== {1'b0, 19'h1}) begin errors++; $display("FAIL fft_ctrl_busy got err=%b data=%0h want 0/1", r_err, r_data); end
    do_req(1'b1, 19'h7F000, 19'd1);
    checks++; if ({r_err, s_fft} !== 2'b10) begin errors++; $display("FAIL fft_restart got err=%b start=%b want 1/0", r_err, s_fft); end
  endtask

  task automatic test_fft_wait();
    logic bad;
    bad = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; addr = 19'h7F001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (req_ready !== 1'b0 || rsp_valid !== 1'b0) bad = 1'b1;
    end
    fft_done = 1'b1; fft_result = 19'd138;
    @(posedge clk); #1;
    fft_done = 1'b0; fft_result = 19'd0;
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL fft_wait_hold got early ready/rsp=%b want 0", bad); end
    @(negedge clk);
    checks++; if ({rsp_valid, err, read_data} !== {2'b10, 19'd138}) begin errors++; $display("FAIL fft_wait_rsp got v=%b err=%b data=%0d want 1/0/138", rsp_valid, err, read_data); end
    do_req(1'b0, 19'h7F000, 19'd0);
    checks++; if ({r_err, r_data} !== {1'b0, 19'h2}) begin errors++; $display("FAIL fft_ctrl_done got err=%b data=%0h want 0/2", r_err, r_data); end
    do_req(1'b0, 19'h7F001, 19'd0);
    checks++; if ({r_wait, r_err, r_data} !== {32'd0, 1'b0, 19'd138}) begin errors++; $display("FAIL fft_result_reg got wait=%0d err=%b data=%0d want 0/0/138", r_wait, r_err, r_data); end
  endtask

  task automatic test_crypto();
    do_req(1'b1, 19'h06001, 19'd255);
    do_req(1'b1, 19'h06002, 19'd77);
    do_req(1'b1, 19'h06000, 19'd1);
    checks++; if ({r_err, s_cr} !== 2'b01) begin errors++; $display("FAIL cr_start got err=%b start=%b want 0/1", r_err, s_cr); end
    checks++; if ({crypto_key, crypto_din} !== {19'd255, 19'd77}) begin errors++; $display("FAIL cr_regs got key=%0d din=%0d want 255/77", crypto_key, crypto_din); end
    do_req(1'b1, 19'h06001, 19'd5);
    checks++; if ({r_err, crypto_key} !== {1'b1, 19'd255}) begin errors++; $display("FAIL cr_key_busy got err=%b key=%0d want 1/255", r_err, crypto_key); end
    do_req(1'b0, 19'h06003, 19'd0);
    checks++; if ({r_wait, r_err, r_data} !== {32'd256, 1'b1, 19'd0}) begin errors++; $display("FAIL cr_timeout got wait=%0d err=%b data=%0d want 256/1/0", r_wait, r_err, r_data); end
    checks++; if (rdy_seen !== 1'b0) begin errors++; $display("FAIL cr_wait_ready got %b want 0", rdy_seen); end
    do_req(1'b0, 19'h06000, 19'd0);
    checks++; if ({r_err, r_data} !== {1'b0, 19'h1}) begin errors++; $display("FAIL cr_busy_after_to got err=%b data=%0h want 0/1", r_err, r_data); end
    do_req(1'b0, 19'h06009, 19'd0);
    checks++; if ({r_wait, r_err, r_data} !== {32'd0, 1'b1, 19'd0}) begin errors++; $display("FAIL cr_unmapped got wait=%0d err=%b data=%0d want 0/1/0", r_wait, r_err, r_data); end
  endtask

  task automatic test_reset_in_wait();
    logic bad;
    bad = 1'b0;
    do_req(1'b1, 19'h7F000, 19'd1);
    checks++; if ({r_err, s_fft} !== 2'b01) begin errors++; $display("FAIL riw_start got err=%b start=%b want 0/1", r_err, s_fft); end
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; addr = 19'h7F001;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL riw_in_wait got ready=%b want 0", req_ready); end
    rst_n = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid !== 1'b0) bad = 1'b1;
    end
    checks++; if (bad !== 1'b0) begin errors++; $display("FAIL riw_no_rsp got stale rsp=%b want 0", bad); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL riw_ready got %b want 1", req_ready); end
    fft_done = 1'b1; fft_result = 19'd99;
    @(posedge clk); #1;
    fft_done = 1'b0; fft_result = 19'd0;
    do_req(1'b0, 19'h7F000, 19'd0);
    checks++; if ({r_wait, r_err, r_data} !== {32'd0, 1'b0, 19'h0}) begin errors++; $display("FAIL riw_ctrl got wait=%0d err=%b data=%0h want 0/0/0", r_wait, r_err, r_data); end
    do_req(1'b0, 19'h7F001, 19'd0);
    checks++; if ({r_err, r_data} !== {1'b0, 19'd0}) begin errors++; $display("FAIL riw_result got err=%b data=%0d want 0/0", r_err, r_data); end
  endtask

  initial begin
    test_reset();
    test_ram();
    test_fft_start();
    test_fft_wait();
    test_crypto();
    test_reset_in_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
# mmio_responder

Memory-side responder for the load/store requests issued by `mem_stage`. Decodes the 19-bit address into data RAM, FFT register window and crypto register window; services reads and writes with a registered response. Issues start pulses to the FFT and crypto accelerators and tracks their busy/done state. Stalls reads of result registers until the accelerator finishes, with a timeout that returns an error.

## Interface
- `DATA_W`, 19, data word width
- `ADDR_W`, 19, request address width
- `RAM_AW`, 8, RAM word-address bits (256 words)
- `FFT_BASE`, 7'h7F, `addr[18:12]` value selecting the FFT window
- `CRYPTO_BASE`, 7'h06, `addr[18:12]` value selecting the crypto window
- `TIMEOUT`, 255, maximum WAIT cycles before an error response

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous active-low reset
- `req_valid`  in  1  request present
- `req_write`  in  1  1 = write, 0 = read
- `addr`  in  19  byte-agnostic word address
- `write_data`  in  19  write payload
- `req_ready`  out  1  request accepted when `req_valid & req_ready`
- `rsp_valid`  out  1  one-cycle response strobe (reads and writes)
- `read_data`  out  19  read result, 0 for writes and errors
- `err`  out  1  qualifies `rsp_valid`; bad address, illegal access or timeout
- `fft_start`  out  1  one-cycle FFT start pulse
- `fft_done`  in  1  one-cycle FFT completion pulse
- `fft_result`  in  19  valid with `fft_done`
- `crypto_start`  out  1  one-cycle crypto start pulse
- `crypto_key`  out  19  KEY register
- `crypto_din`  out  19  DIN register
- `crypto_done`  in  1  one-cycle crypto completion pulse
- `crypto_dout`  in  19  valid with `crypto_done`

## Operation
- Decode: `addr[18:12]==FFT_BASE` → FFT window; `==CRYPTO_BASE` → crypto window; otherwise → RAM at `addr[RAM_AW-1:0]`. Upper RAM bits are ignored (aliasing).
- FFT window, offset `addr[3:0]`:
  - 0x0 CTRL: write bit0=1 starts. Read returns {busy, done} as bit0=busy, bit1=done.
  - 0x1 RESULT: read-only; reads wait while busy.
- Crypto window:
  - 0x0 CTRL: same format as FFT CTRL.
  - 0x1 KEY: RW.
  - 0x2 DIN: RW.
  - 0x3 DOUT: read-only; reads wait while busy.
- Unmapped offsets, writes to read-only registers, and KEY/DIN writes while crypto busy → `err=1`, `read_data=0`, no state change.
- Start while busy → `err=1`, ignored. Effective busy is `busy & ~done`, so a start coinciding with `done` is accepted.
- Start accepted: `*_start` pulses in the next cycle, busy is set, and the sticky done flag clears.
- `*_done` while busy: latch the result into an internal register, clear busy, set sticky done. `*_done` while not busy is ignored.
- FSM states:
  - IDLE (`req_ready=1`): on accept → RESP, or → WAIT for a result read while busy.
  - WAIT: counter increments each cycle.
    - On `*_done` → RESP with `fft_result`/`crypto_dout`.
    - On counter==TIMEOUT → RESP with `err=1`, `read_data=0`; busy stays set.
  - RESP: `rsp_valid=1` for one cycle → IDLE.

## Timing
- Reset values:
  - `req_ready=0` during reset, 1 in the first cycle after reset.
  - `rsp_valid=0`, `err=0`, `read_data=0`, `fft_start=0`, `crypto_start=0`, `crypto_key=0`, `crypto_din=0`.
  - Busy/done flags, result registers and the WAIT counter are 0. RAM contents are not reset.
- Accept at edge T → `rsp_valid` in cycle T+1. Throughput is one request per 2 cycles.
- WAIT: `fft_done` sampled at edge D → `rsp_valid` in cycle D+1.
- Write side effects (RAM, registers, start) commit at the accepting edge. `*_start` is high in cycle T+1 only.
- `read_data` and `err` are meaningful only while `rsp_valid=1` and are held at 0 otherwise.
- Reset mid-WAIT: return to IDLE, drop the pending response, clear busy. A later stale `done` is ignored.

## Structure
- Package `soc_mmio_pkg` holds:
  - `DATA_W`, `ADDR_W`
  - window base constants
  - register offset constants
  - FSM state enum {IDLE, WAIT, RESP}
- Sub-module `mmio_ram`: single-port synchronous RAM, 1-cycle read, write-first; instantiated once.
- FFT and crypto busy/done tracking uses the same logic twice; a small internal function or duplicated always-blocks, with no further sub-module.

## Test plan
- Write 123 to 0x00100, then read 0x00100 → `rsp_valid` one cycle after each accept; read returns 123 with `err=0`.
- Write 1 to 0x7F000 → `fft_start` high for exactly cycle T+1. Read 0x7F000 → 0x1. Second start write → `err=1`, no pulse.
- Read 0x7F001 while busy; drive `fft_done` with `fft_result=138` 5 cycles later → `req_ready=0` throughout; `rsp_valid` the cycle after done with 138. CTRL then reads 0x2.
- Write 255 to 0x06001 and 77 to 0x06002, start via 0x06000 → `crypto_key=255`, `crypto_din=77`. KEY write while busy → `err=1`, key unchanged.
- Read 0x06003 with no `crypto_done` → `rsp_valid`, `err=1`, `read_data=0` after TIMEOUT+1 WAIT cycles. Read 0x06009 → immediate `err=1`.
- Deassert `rst_n` during WAIT → no response. First post-reset request is serviced normally; a late `fft_done` does not set done.
